// File: rtl/gpio_in_debounce_if.sv
// rtl/gpio_in_debounce_if.sv - pad-to-GPIO-core conditioning bus; GPIO_DEB_IRQ_EN adds interrupt signals
interface gpio_in_debounce_if #(
    parameter int W = 32
);
    logic [W-1:0] pad_i;
    logic         deb_en;
    logic [W-1:0] gpio_io_i;
    logic [W-1:0] chg_pulse;
    logic         busy;
`ifdef GPIO_DEB_IRQ_EN
    logic [W-1:0] irq_mask;
    logic [W-1:0] irq_clr;
    logic [W-1:0] irq_status;
    logic         irq;

    modport master (
        output pad_i, deb_en, irq_mask, irq_clr,
        input  gpio_io_i, chg_pulse, busy, irq_status, irq
    );
    modport slave (
        input  pad_i, deb_en, irq_mask, irq_clr,
        output gpio_io_i, chg_pulse, busy, irq_status, irq
    );
`else
    modport master (
        output pad_i, deb_en,
        input  gpio_io_i, chg_pulse, busy
    );
    modport slave (
        input  pad_i, deb_en,
        output gpio_io_i, chg_pulse, busy
    );
`endif
endinterface

// File: rtl/gpio_in_debounce.sv
// rtl/gpio_in_debounce.sv - per-bit synchronizer + stability-count debouncer; GPIO_DEB_IRQ_EN adds change interrupts
module gpio_in_debounce #(
    parameter int C_GPIO_WIDTH  = 32,
    parameter int C_SYNC_STAGES = 2,
    parameter int C_DEB_CYCLES  = 16
) (
    input logic                clk,
    input logic                rst,
    gpio_in_debounce_if.slave  bus
);
    localparam int CW = $clog2(C_DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(C_DEB_CYCLES - 1);

    typedef enum logic {ST_STABLE, ST_COUNT} state_t;

    logic [C_GPIO_WIDTH-1:0] sync_q [C_SYNC_STAGES];
    logic [C_GPIO_WIDTH-1:0] sync;
    logic                    deb_en_q;

    state_t                  state_q [C_GPIO_WIDTH];
    state_t                  state_d [C_GPIO_WIDTH];
    logic [CW-1:0]           cnt_q   [C_GPIO_WIDTH];
    logic [CW-1:0]           cnt_d   [C_GPIO_WIDTH];

    logic [C_GPIO_WIDTH-1:0] gpio_q, gpio_d;
    logic [C_GPIO_WIDTH-1:0] chg_q, chg_d;
    logic                    busy_q, busy_d;

    assign sync = sync_q[C_SYNC_STAGES-1];

    // Synchronizer chain and deb_en history (history tracks even in reset so release is not seen as a toggle)
    always_ff @(posedge clk) begin
        deb_en_q <= bus.deb_en;
        if (rst) begin
            for (int s = 0; s < C_SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= bus.pad_i;
            for (int s = 1; s < C_SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < C_GPIO_WIDTH; b++) begin
                state_q[b] <= ST_STABLE;
                cnt_q[b]   <= '0;
            end
            gpio_q <= '0;
            chg_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            for (int b = 0; b < C_GPIO_WIDTH; b++) begin
                state_q[b] <= state_d[b];
                cnt_q[b]   <= cnt_d[b];
            end
            gpio_q <= gpio_d;
            chg_q  <= chg_d;
            busy_q <= busy_d;
        end
    end

    // Next-state: a deb_en toggle only restarts counting; bypass follows sync; otherwise per-bit debounce
    always_comb begin
        gpio_d = gpio_q;
        chg_d  = '0;
        busy_d = 1'b0;
        for (int b = 0; b < C_GPIO_WIDTH; b++) begin
            state_d[b] = state_q[b];
            cnt_d[b]   = cnt_q[b];
        end
        if (bus.deb_en != deb_en_q) begin
            for (int b = 0; b < C_GPIO_WIDTH; b++) begin
                state_d[b] = ST_STABLE;
                cnt_d[b]   = '0;
            end
        end else if (!bus.deb_en) begin
            gpio_d = sync;
            chg_d  = sync ^ gpio_q;
            for (int b = 0; b < C_GPIO_WIDTH; b++) begin
                state_d[b] = ST_STABLE;
                cnt_d[b]   = '0;
            end
        end else begin
            for (int b = 0; b < C_GPIO_WIDTH; b++) begin
                case (state_q[b])
                    ST_STABLE: begin
                        if (sync[b] != gpio_q[b]) begin
                            if (C_DEB_CYCLES == 1) begin
                                gpio_d[b] = sync[b];
                                chg_d[b]  = 1'b1;
                            end else begin
                                state_d[b] = ST_COUNT;
                                cnt_d[b]   = CW'(1);
                            end
                        end
                    end
                    ST_COUNT: begin
                        if (sync[b] == gpio_q[b]) begin
                            state_d[b] = ST_STABLE;
                            cnt_d[b]   = '0;
                        end else if (cnt_q[b] == CNT_LAST) begin
                            gpio_d[b]  = sync[b];
                            chg_d[b]   = 1'b1;
                            state_d[b] = ST_STABLE;
                            cnt_d[b]   = '0;
                        end else begin
                            cnt_d[b] = cnt_q[b] + CW'(1);
                        end
                    end
                    default: begin
                        state_d[b] = ST_STABLE;
                        cnt_d[b]   = '0;
                    end
                endcase
            end
        end
        for (int b = 0; b < C_GPIO_WIDTH; b++) begin
            if (state_d[b] == ST_COUNT) busy_d = 1'b1;
        end
    end

    assign bus.gpio_io_i = gpio_q;
    assign bus.chg_pulse = chg_q;
    assign bus.busy      = busy_q;

`ifdef GPIO_DEB_IRQ_EN
    logic [C_GPIO_WIDTH-1:0] irq_status_q;
    logic                    irq_q;

    // Sticky change status (a new set beats a simultaneous clear) and its registered summary
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_status_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            irq_status_q <= (irq_status_q & ~bus.irq_clr) | (chg_q & bus.irq_mask);
            irq_q        <= |irq_status_q;
        end
    end

    assign bus.irq_status = irq_status_q;
    assign bus.irq        = irq_q;
`endif
endmodule
